// File: rtl/clk_div_pkg.sv
// Shared types, defaults and config sanitising for the programmable clock divider.
package clk_div_pkg;

  localparam int DEF_DIV  = 256;
  localparam int DEF_HIGH = 128;
  localparam int CFG_W    = 32;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } chan_state_t;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
  } chan_cfg_t;

  // Periods below 2 cannot toggle; an empty or full high phase falls back to a half duty cycle.
  function automatic chan_cfg_t sanitize_cfg(input logic [CFG_W-1:0] div,
                                             input logic [CFG_W-1:0] high);
    chan_cfg_t r;
    r.div  = (div < CFG_W'(2)) ? CFG_W'(2) : div;
    r.high = ((high == '0) || (high >= r.div)) ? (r.div >> 1) : high;
    return r;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadow config, period counter, IDLE/RUN FSM and registered outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CW       = 16,
  parameter int DEF_DIV  = clk_div_pkg::DEF_DIV,
  parameter int DEF_HIGH = clk_div_pkg::DEF_HIGH
) (
  input  logic          clk_in,
  input  logic          resetn,
  input  logic          en,
  input  logic          wr,
  input  logic [CW-1:0] wr_div,
  input  logic [CW-1:0] wr_high,
  output logic          pend,
  output chan_state_t   state,
  output logic          clk_out,
  output logic          tick
);

  localparam logic [CW-1:0] DIV_RST  = CW'(DEF_DIV);
  localparam logic [CW-1:0] HIGH_RST = CW'(DEF_HIGH);

  logic [CW-1:0] cnt;
  logic [CW-1:0] div_a;
  logic [CW-1:0] high_a;
  logic [CW-1:0] div_s;
  logic [CW-1:0] high_s;
  logic [CW-1:0] cnt_inc;
  logic          at_boundary;

  assign cnt_inc     = cnt + CW'(1);
  assign at_boundary = (cnt == div_a - CW'(1));

  // wr is only ever raised while pend is clear, so loading and applying the shadow never collide.
  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      state   <= CH_IDLE;
      cnt     <= '0;
      div_a   <= DIV_RST;
      high_a  <= HIGH_RST;
      div_s   <= DIV_RST;
      high_s  <= HIGH_RST;
      pend    <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (wr) begin
        div_s  <= wr_div;
        high_s <= wr_high;
        pend   <= 1'b1;
      end
      case (state)
        CH_IDLE: begin
          if (pend) begin
            div_a  <= div_s;
            high_a <= high_s;
            pend   <= 1'b0;
          end
          if (en) begin
            state   <= CH_RUN;
            cnt     <= '0;
            clk_out <= 1'b1;
            tick    <= 1'b1;
          end
        end
        CH_RUN: begin
          if (at_boundary) begin
            if (pend) begin
              div_a  <= div_s;
              high_a <= high_s;
              pend   <= 1'b0;
            end
            cnt <= '0;
            if (!en) begin
              state   <= CH_IDLE;
              clk_out <= 1'b0;
              tick    <= 1'b0;
            end else begin
              clk_out <= 1'b1;
              tick    <= 1'b1;
            end
          end else begin
            cnt     <= cnt_inc;
            clk_out <= (cnt_inc < high_a);
            tick    <= 1'b0;
          end
        end
        default: begin
          state <= CH_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable divider: config decode, ready mux and per-channel instances.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int CW       = 16,
  parameter int DEF_DIV  = clk_div_pkg::DEF_DIV,
  parameter int DEF_HIGH = clk_div_pkg::DEF_HIGH,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk_in,
  input  logic           resetn,
  input  logic [NCH-1:0] en,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  input  logic [CW-1:0]  cfg_high,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] run
);

  logic [NCH-1:0]        pend;
  logic [(1<<CHW)-1:0]   pend_pad;
  logic                  cfg_acc;
  chan_cfg_t             cfg_san;
  logic [CW-1:0]         san_div;
  logic [CW-1:0]         san_high;
  logic                  unused_san;
  chan_state_t           ch_state [NCH];

  // Out-of-range channel numbers read as never pending, so such writes are accepted and dropped.
  for (genvar g = 0; g < (1 << CHW); g++) begin : g_pad
    if (g < NCH) begin : g_real
      assign pend_pad[g] = pend[g];
    end else begin : g_void
      assign pend_pad[g] = 1'b0;
    end
  end

  // Handshake: a write transfers on a clock edge where cfg_valid & cfg_ready; cfg_ready
  // depends only on cfg_ch and that channel's pend flag, never on cfg_valid.
  assign cfg_ready = ~pend_pad[cfg_ch];
  assign cfg_acc   = cfg_valid & cfg_ready;

  assign cfg_san    = sanitize_cfg(CFG_W'(cfg_div), CFG_W'(cfg_high));
  assign san_div    = cfg_san.div[CW-1:0];
  assign san_high   = cfg_san.high[CW-1:0];
  assign unused_san = ^{cfg_san.div, cfg_san.high};

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clk_div_chan #(
      .CW       (CW),
      .DEF_DIV  (DEF_DIV),
      .DEF_HIGH (DEF_HIGH)
    ) u_chan (
      .clk_in  (clk_in),
      .resetn  (resetn),
      .en      (en[g]),
      .wr      (cfg_acc && (cfg_ch == CHW'(g))),
      .wr_div  (san_div),
      .wr_high (san_high),
      .pend    (pend[g]),
      .state   (ch_state[g]),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
    assign run[g] = (ch_state[g] == CH_RUN);
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: period-level reference model, decoupled output monitor.
module tb_clk_div_prog;

  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int CHW = 2;
  localparam int W   = 3 * NCH;

  logic           clk_in = 1'b0;
  logic           resetn;
  logic [NCH-1:0] en;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic [CW-1:0]  cfg_high;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] run;

  clk_div_prog #(
    .NCH      (NCH),
    .CW       (CW),
    .DEF_DIV  (256),
    .DEF_HIGH (128)
  ) dut (
    .clk_in    (clk_in),
    .resetn    (resetn),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .clk_out   (clk_out),
    .tick      (tick),
    .run       (run)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  int         errors = 0;
  int         checks = 0;
  logic [W-1:0] exp_q[$];
  bit         mon_en = 1'b0;

  // reference model: position within the current period plus active and shadow configs
  bit m_run [NCH];
  bit m_pend[NCH];
  int m_pos [NCH];
  int m_div [NCH];
  int m_high[NCH];
  int s_div [NCH];
  int s_high[NCH];

  logic [NCH-1:0] en_v;
  bit             cv_v;
  int             ch_v, d_v, h_v;
  bit             last_acc;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_run[c]  = 1'b0;
      m_pend[c] = 1'b0;
      m_pos[c]  = 0;
      m_div[c]  = 256;
      m_high[c] = 128;
      s_div[c]  = 256;
      s_high[c] = 128;
    end
  endtask

  function automatic void sanitize(input int d, input int h, output int od, output int oh);
    od = (d < 2) ? 2 : d;
    oh = ((h == 0) || (h >= od)) ? od / 2 : h;
  endfunction

  // driver: one clock of stimulus, model advanced to the output shown after the next edge
  task automatic step();
    logic [W-1:0] ev;
    bit rdy, acc;
    int sd, sh;
    @(negedge clk_in);
    en        = en_v;
    cfg_valid = cv_v;
    cfg_ch    = ch_v[CHW-1:0];
    cfg_div   = d_v[CW-1:0];
    cfg_high  = h_v[CW-1:0];
    #1;
    rdy = (ch_v >= NCH) ? 1'b1 : !m_pend[ch_v];
    check("cfg_ready", W'(cfg_ready), W'(rdy));
    acc      = cv_v && rdy;
    last_acc = acc;
    sanitize(d_v, h_v, sd, sh);
    for (int c = 0; c < NCH; c++) begin
      if (!m_run[c]) begin
        if (m_pend[c]) begin
          m_div[c] = s_div[c]; m_high[c] = s_high[c]; m_pend[c] = 1'b0;
        end
        if (en_v[c]) begin
          m_run[c] = 1'b1; m_pos[c] = 0;
        end
      end else if (m_pos[c] == m_div[c] - 1) begin
        if (m_pend[c]) begin
          m_div[c] = s_div[c]; m_high[c] = s_high[c]; m_pend[c] = 1'b0;
        end
        m_pos[c] = 0;
        if (!en_v[c]) m_run[c] = 1'b0;
      end else begin
        m_pos[c]++;
      end
      if (acc && (ch_v == c)) begin
        s_div[c] = sd; s_high[c] = sh; m_pend[c] = 1'b1;
      end
    end
    ev = '0;
    for (int c = 0; c < NCH; c++) begin
      ev[2*NCH + c] = m_run[c];
      ev[NCH + c]   = m_run[c] && (m_pos[c] < m_high[c]);
      ev[c]         = m_run[c] && (m_pos[c] == 0);
    end
    exp_q.push_back(ev);
    mon_en = 1'b1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pos(input int c, input int p);
    for (int i = 0; i < 600 && !(m_run[c] && m_pos[c] == p); i++) step();
    checks++;
    if (!(m_run[c] && m_pos[c] == p)) begin
      errors++;
      $display("FAIL wait_pos: channel %0d never reached position %0d", c, p);
    end
  endtask

  task automatic wait_accept();
    last_acc = 1'b0;
    for (int i = 0; i < 400 && !last_acc; i++) step();
    checks++;
    if (!last_acc) begin
      errors++;
      $display("FAIL wait_accept: write on channel %0d never accepted", ch_v);
    end
  endtask

  task automatic reset_mid();
    @(negedge clk_in);
    mon_en = 1'b0;
    #2;
    resetn    = 1'b0;
    en        = '0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    en_v      = '0;
    cv_v      = 1'b0;
    ch_v      = 0;
    #1;
    check("reset_mid_out", {run, clk_out, tick}, '0);
    check("reset_mid_ready", W'(cfg_ready), W'(1'b1));
    model_reset();
    exp_q.delete();
    @(negedge clk_in);
    resetn = 1'b1;
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk_in);
      #1;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL queue_empty: no expected value at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("outputs{run,clk_out,tick}", {run, clk_out, tick}, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_high = '0;
    en_v = '0; cv_v = 1'b0; ch_v = 0; d_v = 0; h_v = 0;
    model_reset();
    #1;
    check("reset_out", {run, clk_out, tick}, '0);
    check("reset_ready", W'(cfg_ready), W'(1'b1));
    repeat (3) @(negedge clk_in);
    resetn = 1'b1;

    // defaults on channel 0 only
    en_v = 3'b001;
    run_n(600);

    // mid-period write, then a stalled second write that also exercises sanitising
    wait_pos(0, 100);
    cv_v = 1'b1; ch_v = 0; d_v = 10; h_v = 3;
    step();
    d_v = 9; h_v = 9;
    wait_accept();
    cv_v = 1'b0;
    run_n(40);
    cv_v = 1'b1; d_v = 1; h_v = 0;
    step();
    cv_v = 1'b0;
    run_n(30);

    // stop at cnt=5, then restart and re-raise en before the boundary
    cv_v = 1'b1; d_v = 10; h_v = 3;
    step();
    cv_v = 1'b0;
    run_n(25);
    wait_pos(0, 5);
    en_v[0] = 1'b0;
    run_n(15);
    en_v[0] = 1'b1;
    run_n(12);
    wait_pos(0, 5);
    en_v[0] = 1'b0;
    run_n(2);
    en_v[0] = 1'b1;
    run_n(25);

    // write accepted exactly on a boundary
    wait_pos(0, m_div[0] - 1);
    cv_v = 1'b1; d_v = 6; h_v = 2;
    step();
    cv_v = 1'b0;
    run_n(30);

    // async reset in the high phase with a write pending
    wait_pos(0, 0);
    cv_v = 1'b1; d_v = 20; h_v = 5;
    step();
    cv_v = 1'b0;
    reset_mid();
    en_v = 3'b001;
    run_n(520);

    // randomized traffic on all channels, including discarded channel numbers
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) en_v = 3'($urandom_range(0, 7));
      cv_v = ($urandom_range(0, 3) == 0);
      ch_v = $urandom_range(0, 3);
      d_v  = $urandom_range(0, 14);
      h_v  = $urandom_range(0, 16);
      step();
    end

    cv_v = 1'b0;
    step();
    @(posedge clk_in);
    #2;
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Multi-channel, runtime-programmable clock/strobe divider: the parametrised successor of the fixed single-output divider used for peripheral clock enables (audio, display refresh, PWM base). Each channel derives a divided waveform with programmable period and high time. It also produces a one-cycle `tick` strobe. Channels are started, stopped and reconfigured glitch-free, with changes applied only at period boundaries. It sits between the SoC clock and the peripheral timing logic, driven by a CSR-side config port.

## Interface
- `NCH`, 2: number of independent channels (1..8).
- `CW`, 16: counter/config width; period range 2..2^CW-1.
- `DEF_DIV`, 256: period of every channel after reset.
- `DEF_HIGH`, 128: high time of every channel after reset.
- `clk_in`  in  1  clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `en`  in  NCH  per-channel run request, level.
- `cfg_valid`  in  1  config write request.
- `cfg_ready`  out  1  = ~pend[cfg_ch]; write accepted when `cfg_valid & cfg_ready`.
- `cfg_ch`  in  max(1,$clog2(NCH))  target channel; values ≥NCH are accepted and discarded.
- `cfg_div`  in  CW  requested period, in clk_in cycles.
- `cfg_high`  in  CW  requested high time, in cycles.
- `clk_out`  out  NCH  divided waveform, registered.
- `tick`  out  NCH  1-cycle pulse in the first cycle of every period, registered.
- `run`  out  NCH  channel currently running.

## Operation
- Per channel, state: active `div_a`, `high_a`; shadow `div_s`, `high_s`, `pend`; counter `cnt`; `run`.
- Reset: `cnt=0`, `run=0`, `clk_out=0`, `tick=0`, `pend=0`, `div_a=DEF_DIV`, `high_a=DEF_HIGH`.
- Sanitising is applied on accept, before writing the shadow:
  - `div<2` → 2.
  - `high==0` or `high>=div` → `div>>1` (floor).
- Accept: load the shadow and set `pend`. A second write to a pending channel stalls, because `cfg_ready=0`.
- States per channel: IDLE (`run=0`), RUN.
- IDLE→RUN when `en=1`:
  - Next cycle: `run=1`, `cnt=0`, `clk_out=1`, `tick=1`.
  - If `pend` is set, the shadow is applied together with the start.
- IDLE with `pend` and `en=0`: shadow applied next cycle, `pend` cleared.
- RUN:
  - `cnt` counts 0..div_a-1 and wraps.
  - `clk_out=1` while `cnt<high_a`, else 0.
  - `tick=1` only when `cnt==0`.
- Period boundary means `cnt==div_a-1`. At the boundary:
  - If `pend`: apply the shadow, clear `pend`.
  - If `en=0`: go to IDLE, with `cnt=0` and `clk_out=0` next cycle.
  - Otherwise wrap to 0, `tick=1`.
- `en` dropped mid-period: the period completes; no runt pulse. `en` re-raised before the boundary: the channel keeps running without interruption.
- Accept in the same cycle as a boundary: the shadow is applied at the *next* boundary, not the current one.
- All channels are independent; simultaneous events on different channels do not interact.

## Timing
- Start latency: 1 cycle from `en` sampled high in IDLE to `clk_out`/`tick` high.
- Stop latency: 0..div_a cycles. `run` falls in the cycle after the boundary.
- Config latency, RUN: the new values take effect in the first cycle of the period after the boundary. `cfg_ready` for that channel rises in the same cycle.
- Config latency, IDLE: 1 cycle.
- Period is exactly `div_a` cycles; high phase is exactly `high_a` cycles.
- `clk_out` and `tick` are flop outputs. `cfg_ready` is combinational from `cfg_ch`.
- Async reset mid-period forces all outputs low immediately and discards `pend`.

## Structure
- Package `clk_div_pkg`:
  - `DEF_DIV` / `DEF_HIGH` defaults.
  - Sanitise function: `(div, high)` → legal pair.
  - Per-channel config struct `{div, high}`.
- Sub-module `clk_div_chan`: one channel (counter, shadow, IDLE/RUN FSM, output flops), generated NCH times.
- Top level: config decode/ready mux and the generate loop.

## Test plan
- Reset, then `en[0]=1` with defaults → `clk_out[0]` 128 cycles high, 128 low, repeating; `tick` every 256 cycles; `clk_out[1]=0`, `run[1]=0`.
- While running, write ch0 div=10/high=3 mid-period → current 256-cycle period completes, then 3 high / 7 low; `cfg_ready` low until the boundary.
- Sanitise: write div=1/high=0 → period 2, high 1. Write div=9/high=9 → high 4.
- Drop `en` at `cnt=5` with div=10 → 10-cycle period completes, `run` falls on the next cycle. Re-raise `en` before the boundary → no gap.
- Accept coinciding with `cnt==div_a-1` → old values are used for one more full period.
- Assert `resetn=0` mid-high-phase with a pending config → outputs 0 asynchronously; after release, `en` restarts with 256/128.
